btn_debounce_pulse: RTL and testbench
=====================================

// Module: btn_debounce_pulse
// PURPOSE
//  Input-conditioning stage upstream of the 2-bit JK counter.
//  Synchronises a raw, bouncy push-button, qualifies it with a stability counter and emits
//  one-clock pulses that drive the counter's T (toggle/enable) input, zero-extended to its width.
//  One qualified press gives exactly one count step.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive synchronised cycles at a new level before it is accepted (>=1)
//  REPEAT_CYCLES  8  auto-repeat period in cycles while held (used only with AUTO_REPEAT_EN, >=1)
//  CNT_W          4  width of internal counters; STABLE_CYCLES and REPEAT_CYCLES must be <= 2**CNT_W
// PORTS
//  clk        in   1  rising-edge clock
//  rst        in   1  asynchronous, active-low reset (0 = reset)
//  btn_raw    in   1  asynchronous raw button, 1 = pressed
//  btn_level  out  1  debounced level, registered
//  t_pulse    out  1  one-cycle press pulse -> counter T input
//  rel_pulse  out  1  one-cycle release pulse
// BEHAVIOUR
//  - Reset (rst=0, immediate, async): sync flops=0, state=IDLE, cnt=0, rpt=0, all outputs 0.
//  - Synchroniser: btn_raw -> s1 -> s2 (2 flops); FSM uses s2 only.
//  - FSM states: IDLE(level 0), ARM_HI, HIGH(level 1), ARM_LO.
//    IDLE:   s2=1 -> ARM_HI, cnt<=0.
//    ARM_HI: s2=0 -> IDLE (bounce, no output); else cnt==STABLE_CYCLES-1 -> HIGH,
//            btn_level<=1, t_pulse<=1; else cnt<=cnt+1.
//    HIGH:   s2=0 -> ARM_LO, cnt<=0.
//    ARM_LO: s2=1 -> HIGH (bounce, no output); else cnt==STABLE_CYCLES-1 -> IDLE,
//            btn_level<=0, rel_pulse<=1; else cnt<=cnt+1.
//  - t_pulse/rel_pulse are registered; each is high for exactly one cycle per event.
//  - They never assert in the same cycle.
//  - Latency: counting the first edge that samples btn_raw=1 as edge 1, t_pulse and btn_level
//    rise after edge STABLE_CYCLES+3. Release is symmetric.
//  - An input bounce shorter than STABLE_CYCLES synchronised cycles produces no pulse and no level
//    change. cnt restarts from 0 on every re-entry into an ARM state.
//  - Held button, no macro: one t_pulse per press; further pulses only after a qualified release
//    and a new qualified press.
//  - Reset mid-operation: all state is discarded. If the button is still held when rst returns
//    to 1, it is re-qualified from IDLE and yields a fresh t_pulse after STABLE_CYCLES+3 edges.
//  - Counter widths: cnt and rpt are CNT_W wide. Compare with == only; they never wrap in use.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//   - rpt counter is active in HIGH. It is cleared on entry to HIGH and increments each cycle
//     while in HIGH.
//   - When rpt==REPEAT_CYCLES-1: t_pulse<=1 for one cycle and rpt<=0.
//   - This gives pulses every REPEAT_CYCLES cycles after the initial one.
//   - rpt holds (does not count) in ARM_LO; it is cleared if ARM_LO returns to HIGH.
//  AUTO_REPEAT_EN undefined:
//   - No rpt register; REPEAT_CYCLES is ignored.
//   - Exactly one t_pulse per qualified press.
// TESTING (STABLE_CYCLES=4, REPEAT_CYCLES=8)
//  1. Reset: rst=0 with btn_raw=1 for 10 cycles -> btn_level, t_pulse, rel_pulse stay 0 throughout.
//  2. Clean press: btn_raw 0->1 held 20 cycles -> t_pulse=1 only after edge 7; btn_level=1 from edge 7.
//     Then release -> rel_pulse=1 for one cycle 7 edges later; btn_level=0.
//  3. Press bounce: btn_raw 1x3, 0x2, 1x3, then 0 -> no t_pulse, btn_level stays 0.
//  4. Release glitch: while HIGH, btn_raw=0 for 2 cycles then back to 1 -> no rel_pulse,
//     btn_level stays 1; without the macro, no extra t_pulse.
//  5. Auto-repeat: hold btn_raw=1 for 40 cycles.
//     With AUTO_REPEAT_EN -> t_pulse after edges 7, 15, 23, 31, 39.
//     Without AUTO_REPEAT_EN -> after edge 7 only.
//  6. Reset mid-ARM_HI: btn_raw=1, rst=0 pulsed at edge 4 -> outputs 0 immediately.
//     After rst=1 with button held -> single t_pulse after the 7th edge following reset release.

Source files
------------

// File: rtl/btn_debounce_pulse_if.sv
// Button conditioning bus: raw button in, debounced level and press/release pulses out.
// The master drives btn_raw; the slave (btn_debounce_pulse) drives the conditioned outputs.
interface btn_debounce_pulse_if;
    logic btn_raw;
    logic btn_level;
    logic t_pulse;
    logic rel_pulse;

    modport master (output btn_raw, input btn_level, input t_pulse, input rel_pulse);
    modport slave  (input btn_raw, output btn_level, output t_pulse, output rel_pulse);
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button synchroniser + debouncer producing one-cycle press/release pulses for a counter T input.
// Optional macro AUTO_REPEAT_EN: while held, re-issue t_pulse every REPEAT_CYCLES cycles.
module btn_debounce_pulse #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES = 8,
    parameter int unsigned CNT_W         = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    btn_debounce_pulse_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_q;
    logic             s2_q;
    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             t_q;
    logic             t_d;
    logic             rel_q;
    logic             rel_d;

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    logic [CNT_W-1:0] rpt_q;
    logic [CNT_W-1:0] rpt_d;
`endif

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_raw;
            s2_q <= s1_q;
        end
    end

    // Qualification FSM: next state, stability counter and registered pulse requests
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        t_d     = 1'b0;
        rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_d   = rpt_q;
`endif
        case (state_q)
            IDLE: begin
                if (s2_q) begin
                    state_d = ARM_HI;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            ARM_HI: begin
                if (!s2_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    level_d = 1'b1;
                    t_d     = 1'b1;
`ifdef AUTO_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HIGH: begin
`ifdef AUTO_REPEAT_EN
                // Repeat timer runs on every HIGH cycle, including the one that leaves for ARM_LO
                if (rpt_q == RPT_LAST) begin
                    t_d   = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = rpt_q + CNT_ONE;
                end
`endif
                if (!s2_q) begin
                    state_d = ARM_LO;
                    cnt_d   = '0;
                end else begin
                    state_d = HIGH;
                end
            end
            ARM_LO: begin
                if (s2_q) begin
                    state_d = HIGH;
`ifdef AUTO_REPEAT_EN
                    rpt_d   = '0;
`endif
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                    rel_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
            t_q     <= 1'b0;
            rel_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
            rpt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            t_q     <= t_d;
            rel_q   <= rel_d;
`ifdef AUTO_REPEAT_EN
            rpt_q   <= rpt_d;
`endif
        end
    end

    assign bus.btn_level = level_q;
    assign bus.t_pulse   = t_q;
    assign bus.rel_pulse = rel_q;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Self-checking bench for btn_debounce_pulse: vector table, directed corner sequences and
// random button activity compared against a run-length reference model.
module tb_btn_debounce_pulse;

    localparam int STABLE = 4;
    localparam int REPEAT = 8;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    btn_debounce_pulse_if bif ();

    btn_debounce_pulse #(
        .STABLE_CYCLES (STABLE),
        .REPEAT_CYCLES (REPEAT),
        .CNT_W         (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: two-sample delay line, then a run of samples that disagree with the
    // accepted level; the level flips once the run reaches STABLE+1 consecutive samples.
    logic m_dly [2];
    logic m_level;
    int   m_run;
    int   m_rpt;
    logic m_t;
    logic m_rel;

    typedef struct {
        logic rst;
        logic raw;
        logic lvl;
        logic t;
        logic rel;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        m_dly[0] = 1'b0;
        m_dly[1] = 1'b0;
        m_level  = 1'b0;
        m_run    = 0;
        m_rpt    = 0;
        m_t      = 1'b0;
        m_rel    = 1'b0;
    endfunction

    function automatic void model_edge(input logic r, input logic raw);
        logic seen;
        bit   holding;
        if (!r) begin
            model_reset();
        end else begin
            seen     = m_dly[1];
            m_dly[1] = m_dly[0];
            m_dly[0] = raw;
            m_t      = 1'b0;
            m_rel    = 1'b0;
            holding  = (m_level == 1'b1) && (m_run == 0);
            if (AR && holding) begin
                if (m_rpt == REPEAT - 1) begin
                    m_t   = 1'b1;
                    m_rpt = 0;
                end else begin
                    m_rpt = m_rpt + 1;
                end
            end
            if (seen != m_level) begin
                m_run = m_run + 1;
                if (m_run == STABLE + 1) begin
                    m_level = seen;
                    m_run   = 0;
                    m_rpt   = 0;
                    if (seen) m_t = 1'b1;
                    else      m_rel = 1'b1;
                end
            end else begin
                if (m_level && m_run > 0) m_rpt = 0;
                m_run = 0;
            end
        end
    endfunction

    task automatic step(input logic r, input logic raw);
        rst         = r;
        bif.btn_raw = raw;
        @(posedge clk);
        model_edge(r, raw);
        #1;
        chk("mdl_level", bif.btn_level, m_level);
        chk("mdl_t_pulse", bif.t_pulse, m_t);
        chk("mdl_rel_pulse", bif.rel_pulse, m_rel);
        chk("pulse_exclusive", bif.t_pulse & bif.rel_pulse, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", bif.btn_level, 1'b0);
        chk("async_rst_t", bif.t_pulse, 1'b0);
        chk("async_rst_rel", bif.rel_pulse, 1'b0);
    endtask

    task automatic settle();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0);
    endtask

    function automatic void add(input logic r, input logic raw, input logic lvl,
                                input logic t, input logic rel);
        vec_t v;
        v.rst = r; v.raw = raw; v.lvl = lvl; v.t = t; v.rel = rel;
        vecs.push_back(v);
    endfunction

    initial begin
        logic [63:0] got_mask;
        logic [63:0] exp_mask;
        int          t_cnt;
        int          rel_cnt;
        int          lvl_cnt;
        logic        pat [8];

        bif.btn_raw = 1'b0;
        model_reset();

        // Reset held with button pressed, clean press held 18 edges, then release
        for (int i = 1; i <= 10; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 18; i++)
            add(1'b1, 1'b1, (i >= 7), (i == 7) || (AR && i == 15), 1'b0);
        for (int i = 1; i <= 10; i++) add(1'b1, 1'b0, (i < 7), 1'b0, (i == 7));

        foreach (vecs[k]) begin
            step(vecs[k].rst, vecs[k].raw);
            chk("tbl_level", bif.btn_level, vecs[k].lvl);
            chk("tbl_t_pulse", bif.t_pulse, vecs[k].t);
            chk("tbl_rel_pulse", bif.rel_pulse, vecs[k].rel);
        end
        settle();

        // Press bounce: 1x3, 0x2, 1x3, then released
        pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        t_cnt = 0; lvl_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            step(1'b1, (i < 8) ? pat[i] : 1'b0);
            t_cnt   += int'(bif.t_pulse);
            lvl_cnt += int'(bif.btn_level);
        end
        chk_int("bounce_t_count", t_cnt, 0);
        chk_int("bounce_level_cycles", lvl_cnt, 0);

        // Release glitch right after qualification: 0 for 2 cycles, then held again
        for (int i = 1; i <= 7; i++) step(1'b1, 1'b1);
        chk("glitch_pre_level", bif.btn_level, 1'b1);
        t_cnt = 0; rel_cnt = 0; lvl_cnt = 0;
        for (int i = 8; i <= 16; i++) begin
            step(1'b1, (i == 8 || i == 9) ? 1'b0 : 1'b1);
            t_cnt   += int'(bif.t_pulse);
            rel_cnt += int'(bif.rel_pulse);
            lvl_cnt += int'(!bif.btn_level);
        end
        chk_int("glitch_t_count", t_cnt, 0);
        chk_int("glitch_rel_count", rel_cnt, 0);
        chk_int("glitch_level_low_cycles", lvl_cnt, 0);
        settle();

        // Long hold: pulse positions
        got_mask = 64'd0;
        exp_mask = 64'd0;
        exp_mask[7] = 1'b1;
        if (AR) begin
            exp_mask[15] = 1'b1; exp_mask[23] = 1'b1;
            exp_mask[31] = 1'b1; exp_mask[39] = 1'b1;
        end
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 1'b1);
            got_mask[i] = bif.t_pulse;
        end
        chk_int("hold_t_edges", got_mask, exp_mask);
        settle();

        // Reset during ARM_HI, then re-qualification with button still held
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1);
        async_reset();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        got_mask = 64'd0;
        exp_mask = 64'd0;
        exp_mask[7] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step(1'b1, 1'b1);
            got_mask[i] = bif.t_pulse;
        end
        chk_int("rst_requal_t_edges", got_mask, exp_mask);
        chk("rst_requal_level", bif.btn_level, 1'b1);

        // Reset while HIGH must clear the level at once
        async_reset();
        step(1'b0, 1'b0);
        settle();

        // Random button activity with variable run lengths and one mid-run reset
        for (int k = 0; k < 80; k++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if (k == 40) begin
                async_reset();
                step(1'b0, v);
            end
            for (int j = 0; j < len; j++) step(1'b1, v);
        end
        settle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
